// File: rtl/ctrl_pkg.sv
// Shared opcode, bus-select, state and control-word definitions for the
// microcoded control sequencer.
package ctrl_pkg;

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4;
  localparam logic [3:0] OP_JNC = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JNZ = 4'h7;
  localparam logic [3:0] OP_STA = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] BUS_RAM  = 3'd0;
  localparam logic [2:0] BUS_IR   = 3'd2;
  localparam logic [2:0] BUS_A    = 3'd3;
  localparam logic [2:0] BUS_B    = 3'd4;
  localparam logic [2:0] BUS_ALU  = 3'd5;
  localparam logic [2:0] BUS_PC   = 3'd6;
  localparam logic [2:0] BUS_NULL = 3'd7;

  typedef struct packed {
    logic       halt;
    logic       mem;
    logic       ram;
    logic       inst_in;
    logic       reg_a;
    logic       reg_b;
    logic       sub;
    logic       disp;
    logic       inc;
    logic       jump;
    logic       flag;
    logic [2:0] bus;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    halt: 1'b0, mem: 1'b0, ram: 1'b0, inst_in: 1'b0, reg_a: 1'b0, reg_b: 1'b0,
    sub: 1'b0, disp: 1'b0, inc: 1'b0, jump: 1'b0, flag: 1'b0, bus: BUS_NULL
  };

  // Final microstep of each opcode, indexed by opcode value.
  localparam logic [2:0] LAST_STEP [16] = '{
    3'd2, 3'd4, 3'd4, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2,
    3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2
  };

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational opcode/microstep to control-word decoder.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  input  logic [2:0]     step,
  input  logic           carry,
  input  logic           zero,
  output ctrl_t          ctrl,
  output logic           last,
  output logic           illegal
);

  logic       hi;
  logic [3:0] lo;
  logic [3:0] eop;

  assign lo = op[3:0];

  if (OPW > 4) begin : g_hi
    assign hi = |op[OPW-1:4];
  end else begin : g_no_hi
    assign hi = 1'b0;
  end

  always_comb begin
    illegal = hi || (lo == 4'hA) || (lo == 4'hB) || (lo == 4'hE);
    eop     = illegal ? OP_NOP : lo;
    last    = (step == LAST_STEP[eop]);
    ctrl    = CTRL_IDLE;
    case (step)
      3'd0: begin
        ctrl.mem = 1'b1;
        ctrl.bus = BUS_PC;
      end
      3'd1: begin
        ctrl.inst_in = 1'b1;
        ctrl.inc     = 1'b1;
        ctrl.bus     = BUS_RAM;
      end
      3'd2: begin
        case (eop)
          OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
            ctrl.mem = 1'b1;
            ctrl.bus = BUS_IR;
          end
          OP_JMP: begin
            ctrl.jump = 1'b1;
            ctrl.bus  = BUS_IR;
          end
          OP_JNC, OP_JC, OP_JNZ, OP_JZ: begin
            if ((eop == OP_JNC && !carry) || (eop == OP_JC && carry) ||
                (eop == OP_JNZ && !zero) || (eop == OP_JZ && zero)) begin
              ctrl.jump = 1'b1;
              ctrl.bus  = BUS_IR;
            end
          end
          OP_OUT: begin
            ctrl.disp = 1'b1;
            ctrl.bus  = BUS_A;
          end
          OP_LDI: begin
            ctrl.reg_a = 1'b1;
            ctrl.bus   = BUS_IR;
          end
          OP_HLT: ctrl.halt = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (eop)
          OP_ADD, OP_SUB: begin
            ctrl.reg_b = 1'b1;
            ctrl.bus   = BUS_RAM;
          end
          OP_LDA: begin
            ctrl.reg_a = 1'b1;
            ctrl.bus   = BUS_RAM;
          end
          OP_STA: begin
            ctrl.ram = 1'b1;
            ctrl.bus = BUS_A;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (eop == OP_ADD || eop == OP_SUB) begin
          ctrl.reg_a = 1'b1;
          ctrl.flag  = 1'b1;
          ctrl.sub   = (eop == OP_SUB);
          ctrl.bus   = BUS_ALU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microstep sequencer: owns run/halt state, the step pointer, single-step
// gating and the registered control outputs. State updates on the falling edge.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int STEPW = 3,
  parameter int BSW   = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic [OPW-1:0]   inst,
  input  logic             carryFlag,
  input  logic             zeroFlag,
  input  logic             run,
  input  logic             sstep,
  input  logic             step_req,
  output logic             step_ack,
  output logic             halt,
  output logic             mem,
  output logic             ram,
  output logic             instIn,
  output logic             regA,
  output logic             regB,
  output logic             sub,
  output logic             disp,
  output logic             inc,
  output logic             jump,
  output logic             flag,
  output logic [BSW-1:0]   bus_sel,
  output logic [STEPW-1:0] step,
  output logic             bad_op
);

  state_t           state, state_nxt;
  logic [STEPW-1:0] ptr, ptr_nxt, step_nxt;
  ctrl_t            ctrl_q, ctrl_nxt, dec;
  logic             dec_last, dec_illegal, ack_nxt, bad_nxt, go;
  logic [2:0]       cur;

  // ptr is the next microstep to issue; step shows the one last issued.
  assign cur = (ptr > STEPW'(4)) ? 3'd0 : ptr[2:0];
  assign go  = ((state == RUN) || run) && (!sstep || step_req);

  ctrl_decode #(.OPW(OPW)) u_decode (
    .op      (inst),
    .step    (cur),
    .carry   (carryFlag),
    .zero    (zeroFlag),
    .ctrl    (dec),
    .last    (dec_last),
    .illegal (dec_illegal)
  );

  always_ff @(negedge clk) begin
    if (res) begin
      state    <= RUN;
      ptr      <= '0;
      step     <= '0;
      ctrl_q   <= CTRL_IDLE;
      step_ack <= 1'b0;
      bad_op   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      step     <= step_nxt;
      ctrl_q   <= ctrl_nxt;
      step_ack <= ack_nxt;
      bad_op   <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (go && dec.halt) state_nxt = HALTED;
      HALTED:  if (run) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctrl_nxt = CTRL_IDLE;
    step_nxt = (step > STEPW'(4)) ? '0 : step;
    ptr_nxt  = (ptr > STEPW'(4)) ? '0 : ptr;
    ack_nxt  = 1'b0;
    bad_nxt  = bad_op;
    if (state == HALTED && !run) begin
      ctrl_nxt.halt = 1'b1;
      step_nxt      = '0;
      ptr_nxt       = '0;
    end else if (go) begin
      ctrl_nxt = dec;
      ack_nxt  = sstep;
      if (cur == 3'd2 && dec_illegal) bad_nxt = 1'b1;
      // HLT reports step 0 immediately, since HALTED holds step at 0.
      if (dec.halt) begin
        step_nxt = '0;
        ptr_nxt  = '0;
      end else begin
        step_nxt = STEPW'(cur);
        ptr_nxt  = dec_last ? '0 : STEPW'(cur) + STEPW'(1);
      end
    end
  end

  assign halt    = ctrl_q.halt;
  assign mem     = ctrl_q.mem;
  assign ram     = ctrl_q.ram;
  assign instIn  = ctrl_q.inst_in;
  assign regA    = ctrl_q.reg_a;
  assign regB    = ctrl_q.reg_b;
  assign sub     = ctrl_q.sub;
  assign disp    = ctrl_q.disp;
  assign inc     = ctrl_q.inc;
  assign jump    = ctrl_q.jump;
  assign flag    = ctrl_q.flag;
  assign bus_sel = BSW'(ctrl_q.bus);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a per-opcode behavioural model checked
// every cycle, plus hand-computed literal checks at key microsteps.
module tb_ctrl_sequencer;

  logic       clk, res, carryFlag, zeroFlag, run, sstep, step_req;
  logic [3:0] inst;
  logic       step_ack, halt, mem, ram, instIn, regA, regB, sub, disp, inc, jump, flag, bad_op;
  logic [2:0] bus_sel, step;

  int vectors = 0;
  int miscompares = 0;

  ctrl_sequencer #(.OPW(4), .STEPW(3), .BSW(3)) dut (
    .clk(clk), .res(res), .inst(inst), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
    .run(run), .sstep(sstep), .step_req(step_req), .step_ack(step_ack),
    .halt(halt), .mem(mem), .ram(ram), .instIn(instIn), .regA(regA), .regB(regB),
    .sub(sub), .disp(disp), .inc(inc), .jump(jump), .flag(flag),
    .bus_sel(bus_sel), .step(step), .bad_op(bad_op)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Word bit positions: {halt,mem,ram,instIn,regA,regB,sub,disp,inc,jump,flag,bus[2:0]}
  localparam int H = 13, M = 12, RM = 11, II = 10, RA = 9, RB = 8, SB = 7, DP = 6,
                 IC = 5, JP = 4, FL = 3;

  function automatic logic [13:0] idle_word();
    return {11'b0, 3'd7};
  endfunction

  function automatic logic [13:0] mword(input logic [3:0] op, input int t,
                                        input logic c, input logic z);
    logic [13:0] r;
    logic take;
    r = idle_word();
    take = (op == 4'h5 && !c) || (op == 4'h6 && c) || (op == 4'h7 && !z) || (op == 4'hC && z);
    if (t == 0) begin r[M] = 1; r[2:0] = 3'd6; end
    else if (t == 1) begin r[II] = 1; r[IC] = 1; r[2:0] = 3'd0; end
    else begin
      case (op)
        4'h1, 4'h2: begin
          if (t == 2) begin r[M] = 1; r[2:0] = 3'd2; end
          if (t == 3) begin r[RB] = 1; r[2:0] = 3'd0; end
          if (t == 4) begin r[RA] = 1; r[FL] = 1; r[SB] = (op == 4'h2); r[2:0] = 3'd5; end
        end
        4'h3: if (t == 2) begin r[JP] = 1; r[2:0] = 3'd2; end
        4'h4: begin
          if (t == 2) begin r[M] = 1; r[2:0] = 3'd2; end
          if (t == 3) begin r[RA] = 1; r[2:0] = 3'd0; end
        end
        4'h5, 4'h6, 4'h7, 4'hC: if (t == 2 && take) begin r[JP] = 1; r[2:0] = 3'd2; end
        4'h8: begin
          if (t == 2) begin r[M] = 1; r[2:0] = 3'd2; end
          if (t == 3) begin r[RM] = 1; r[2:0] = 3'd3; end
        end
        4'h9: if (t == 2) begin r[DP] = 1; r[2:0] = 3'd3; end
        4'hD: if (t == 2) begin r[RA] = 1; r[2:0] = 3'd2; end
        4'hF: if (t == 2) r[H] = 1;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic int mlen(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h2) return 5;
    if (op == 4'h4 || op == 4'h8) return 4;
    return 3;
  endfunction

  // Model state and expected outputs after each falling edge.
  int          mt = 0;
  logic        mhalt = 0, mbad = 0, mvalid = 0, eack = 0;
  logic [13:0] ew = 14'h7;
  logic [2:0]  ems = 0;

  always @(negedge clk) begin
    if (res) begin
      mt = 0; mhalt = 0; mbad = 0; ew = idle_word(); ems = 0; eack = 0;
    end else if (mhalt && !run) begin
      ew = idle_word(); ew[H] = 1; ems = 0; eack = 0;
    end else if (sstep && !step_req) begin
      ew = idle_word(); eack = 0; mhalt = 0;
    end else begin
      mhalt = 0;
      ew    = mword(inst, mt, carryFlag, zeroFlag);
      ems   = 3'(mt);
      eack  = sstep;
      if (mt == 2 && (inst == 4'hA || inst == 4'hB || inst == 4'hE)) mbad = 1;
      if (ew[H]) begin mhalt = 1; ems = 0; mt = 0; end
      else if (mt + 1 == mlen(inst)) mt = 0;
      else mt = mt + 1;
    end
    mvalid = 1;
  end

  logic [18:0] dvec, evec;
  assign dvec = {step_ack, bad_op, halt, mem, ram, instIn, regA, regB, sub, disp, inc,
                 jump, flag, bus_sel, step};
  assign evec = {eack, mbad, ew, ems};

  always @(posedge clk) begin
    if (mvalid) begin
      vectors++;
      if (dvec !== evec) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: actual %h required %h", $time, dvec, evec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    res = 1; inst = 0; carryFlag = 0; zeroFlag = 0; run = 0; sstep = 0; step_req = 0;
    cyc(); cyc();
    chk("reset_step", step, 0); chk("reset_bus", bus_sel, 7);
    chk("reset_halt", halt, 0); chk("reset_bad", bad_op, 0);

    // LDI then OUT
    res = 0; inst = 4'hD;
    cyc(); chk("ldi_t0_mem", mem, 1); chk("ldi_t0_bus", bus_sel, 6);
    cyc(); cyc(); chk("ldi_t2_rega", regA, 1); chk("ldi_t2_bus", bus_sel, 2);
    inst = 4'h9;
    cyc(); chk("out_t0_step", step, 0);
    cyc(); cyc(); chk("out_t2_disp", disp, 1); chk("out_t2_bus", bus_sel, 3);

    // ADD then SUB
    inst = 4'h1;
    repeat (5) cyc();
    chk("add_t4_rega", regA, 1); chk("add_t4_flag", flag, 1);
    chk("add_t4_bus", bus_sel, 5); chk("add_t4_sub", sub, 0); chk("add_t4_step", step, 4);
    inst = 4'h2;
    cyc(); chk("sub_t0_step", step, 0);
    repeat (4) cyc();
    chk("sub_t4_sub", sub, 1); chk("sub_t4_bus", bus_sel, 5); chk("sub_t4_flag", flag, 1);

    // Conditional jumps
    inst = 4'h6; carryFlag = 1;
    repeat (3) cyc(); chk("jc_jump", jump, 1); chk("jc_bus", bus_sel, 2);
    inst = 4'hC; carryFlag = 0; zeroFlag = 0;
    repeat (3) cyc(); chk("jz_nojump", jump, 0); chk("jz_idle_bus", bus_sel, 7);
    cyc(); chk("jz_next_t0", step, 0); chk("jz_next_mem", mem, 1);
    repeat (2) cyc();
    inst = 4'h7; zeroFlag = 1;
    cyc(); cyc(); zeroFlag = 0;
    cyc(); chk("jnz_t2_sample", jump, 1);
    zeroFlag = 1;

    // LDA with sstep toggled mid-instruction
    inst = 4'h4;
    cyc(); cyc(); sstep = 1;
    repeat (3) cyc();
    chk("lda_hold_step", step, 1); chk("lda_hold_bus", bus_sel, 7);
    step_req = 1;
    cyc(); chk("lda_t2_mem", mem, 1); chk("lda_t2_ack", step_ack, 1);
    step_req = 0; sstep = 0;
    cyc(); chk("lda_t3_rega", regA, 1); chk("lda_t3_ack", step_ack, 0);

    // HLT, ten idle cycles, then resume
    inst = 4'hF;
    repeat (3) cyc(); chk("hlt_halt", halt, 1);
    inst = 4'h0;
    for (int i = 0; i < 10; i++) begin
      cyc(); chk("halted_halt", halt, 1); chk("halted_step", step, 0);
    end
    run = 1;
    cyc(); chk("resume_halt", halt, 0); chk("resume_step", step, 0); chk("resume_mem", mem, 1);
    run = 0;
    repeat (2) cyc();

    // Single-stepped ADD, one request every four cycles
    inst = 4'h1; sstep = 1; acks = 0;
    for (int i = 0; i < 5; i++) begin
      step_req = 1;
      cyc(); acks += int'(step_ack);
      step_req = 0;
      repeat (3) begin cyc(); acks += int'(step_ack); end
    end
    chk("sstep_ack_count", acks, 5);
    sstep = 0;

    // Reset during T3 of STA
    inst = 4'h8;
    repeat (3) cyc(); chk("sta_t2_mem", mem, 1);
    res = 1;
    cyc(); chk("sta_reset_ram", ram, 0); chk("sta_reset_step", step, 0);
    res = 0;
    cyc(); chk("sta_after_t0", step, 0); chk("sta_after_mem", mem, 1);
    repeat (3) cyc();

    // Illegal opcode sets sticky bad_op
    inst = 4'hA;
    repeat (3) cyc(); chk("illegal_bad", bad_op, 1);
    inst = 4'h0;
    repeat (3) cyc(); chk("illegal_sticky", bad_op, 1);
    res = 1;
    cyc(); chk("illegal_cleared", bad_op, 0);
    res = 0;
    cyc(); chk("post_reset_mem", mem, 1);

    // Reset while HALTED
    inst = 4'hF;
    cyc(); cyc(); chk("hlt2_halt", halt, 1);
    res = 1;
    cyc(); chk("halted_reset_halt", halt, 0);
    res = 0; inst = 4'h0;
    cyc(); chk("halted_reset_t0", mem, 1); chk("halted_reset_step", step, 0);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and res.
REQ-002 Parameters SHALL be (name, default, meaning):
  - OPW, 4: opcode width.
  - STEPW, 3: microstep counter width; minimum 3.
  - BSW, 3: bus-select width; minimum 3.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - clk: in, 1, clock; all state updates on the falling edge.
  - res: in, 1, synchronous active-high reset.
  - inst: in, OPW, opcode from the instruction register.
  - carryFlag: in, 1, ALU carry flag.
  - zeroFlag: in, 1, ALU zero flag.
  - run: in, 1, resume request from HALTED.
  - sstep: in, 1, single-step mode enable.
  - step_req: in, 1, single-step advance request.
  - step_ack: out, 1, one-cycle acknowledge of an issued microstep.
  - halt, mem, ram, instIn, regA, regB, sub, disp, inc, jump, flag: out, 1 each, registered control strobes.
  - bus_sel: out, BSW, bus driver select.
  - step: out, STEPW, current microstep.
  - bad_op: out, 1, sticky illegal-opcode indicator.

Function
REQ-004 The block SHALL have two states: RUN and HALTED.
REQ-005 All outputs SHALL be registered.
REQ-006 Every strobe not named for a microstep SHALL be 0 in that microstep, and an idle bus_sel SHALL be BUS_NULL.
REQ-007 T0 SHALL drive mem=1 and bus_sel=BUS_PC.
REQ-008 T1 SHALL drive instIn=1, inc=1 and bus_sel=BUS_RAM.
REQ-009 Opcode execution from T2 SHALL be as follows (x = step T-number):
  - 0 NOP: T2 idle.
  - 1 ADD: T2 mem, IR; T3 regB, RAM; T4 regA, flag, ALU.
  - 2 SUB: same as ADD, plus sub=1 at T4.
  - 3 JMP: T2 jump, IR.
  - 4 LDA: T2 mem, IR; T3 regA, RAM.
  - 5 JNC, 6 JC, 7 JNZ, C JZ: T2 jump, IR when the condition holds; otherwise T2 idle.
  - 8 STA: T2 mem, IR; T3 ram, A.
  - 9 OUT: T2 disp, A.
  - D LDI: T2 regA, IR.
  - F HLT: see REQ-012.
  - A, B, E: illegal.
REQ-010 The last microstep of each opcode SHALL return step to 0 at the next edge, with no trailing idle cycle. Instruction latency SHALL be 3, 4 or 5 cycles.
REQ-011 Conditional jumps SHALL sample carryFlag and zeroFlag at the T2 edge only.
REQ-012 HLT at T2 SHALL set halt=1 and enter HALTED. halt SHALL stay 1 while HALTED.
REQ-013 In HALTED, the block SHALL hold step=0 and all other strobes 0.
REQ-014 In HALTED, run=1 SHALL return the block to RUN at T0 on the next edge, with halt=0.
REQ-015 An illegal opcode, or any nonzero opcode bit above bit 3 when OPW>4, SHALL execute as NOP and set bad_op=1.
REQ-016 bad_op SHALL be cleared only by res.
REQ-017 With sstep=0, the block SHALL advance one microstep per cycle, and step_ack SHALL be 0.
REQ-018 With sstep=1, a microstep SHALL be issued only on edges where step_req=1. That edge SHALL drive the microstep's strobes for exactly one cycle and step_ack=1 for one cycle.
REQ-019 With sstep=1, on edges where step_req=0, all strobes SHALL be 0, bus_sel SHALL be BUS_NULL and step SHALL hold.
REQ-020 Toggling sstep mid-instruction SHALL neither skip nor repeat microsteps.
REQ-021 step SHALL never exceed 4. Any value above 4 SHALL force step to 0 on the next edge.

Reset
REQ-022 When res=1 at a falling edge, the block SHALL apply all of the following, overriding run, sstep and step_req:
  - state RUN and step=0;
  - all strobes 0, including halt;
  - bus_sel=BUS_NULL;
  - step_ack=0 and bad_op=0.
REQ-023 A reset during any microstep, or during HALTED, SHALL abandon the instruction. The first edge after res falls SHALL issue T0.

Structure
REQ-024 A shared package ctrl_pkg SHALL hold:
  - the opcode constants;
  - the bus-select constants: BUS_RAM=0, BUS_IR=2, BUS_A=3, BUS_B=4, BUS_ALU=5, BUS_PC=6, BUS_NULL=7;
  - the state enum;
  - the last-step-per-opcode table.
REQ-025 Opcode-and-step to control-word decoding SHALL be one combinational sub-module, ctrl_decode. ctrl_sequencer SHALL own the state, the step counter, gating and the output registers.

Verification
REQ-026 LDI then OUT: inst=D then 9, sstep=0 → regA at T2 (bus_sel=2) of instruction 1; disp at T2 (bus_sel=3) of instruction 2; each instruction takes 3 cycles.
REQ-027 ADD then SUB: inst=1 then 2 → T4 shows regA=1, flag=1, bus_sel=5 in both; sub=1 only for SUB; each instruction takes 5 cycles.
REQ-028 Conditional jumps: JC with carryFlag=1 → jump=1 at T2; JZ with zeroFlag=0 → no jump, and the next cycle is T0.
REQ-029 HLT: inst=F, then run held low 10 cycles, then run=1 → halt=1 for all 10 cycles; T0 follows the run edge.
REQ-030 Single-step: sstep=1, one step_req pulse every 4 cycles during ADD → exactly 5 step_ack pulses; strobes high only on request edges.
REQ-031 Reset and illegal opcode: res=1 at T3 of STA → no ram strobe; T0 on the first free edge. inst=A → bad_op=1 held until res.
